// File: rtl/sys_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_cfg_pkg
// Description : Shared definitions for the UART/ALU configuration register
//               file. It holds the address-width helper, the named register
//               addresses and the default reset-value image.
// Revision    : 1.0 - initial release
// ============================================================================
package sys_cfg_pkg;

    // Named addresses of the exported configuration registers
    localparam int c_addr_reg0 = 0;
    localparam int c_addr_reg1 = 1;
    localparam int c_addr_reg2 = 2;
    localparam int c_addr_reg3 = 3;

    // Default reset contents of the two non-zero registers
    localparam logic [7:0] c_rst_val_reg2 = 8'h81;
    localparam logic [7:0] c_rst_val_reg3 = 8'h20;

    // Upper bound on the reset image produced by default_rst_vals()
    localparam int c_rst_img_bits = 4096;

    // Address width: clog2(depth), but never narrower than one bit
    function automatic int addr_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    // Builds the default flat reset image: 0x81 at reg2, 0x20 at reg3, and
    // zero everywhere else. The caller truncates it to DEPTH*WIDTH bits.
    // Registers narrower than 8 bits take the low bits of each value.
    function automatic logic [c_rst_img_bits-1:0] default_rst_vals(
        input int width,
        input int depth
    );
        logic [c_rst_img_bits-1:0] v;
        v = '0;
        for (int b = 0; b < width; b++) begin
            if (b < 8) begin
                if (depth > c_addr_reg2 && (c_addr_reg2 * width + b) < c_rst_img_bits)
                    v[c_addr_reg2 * width + b] = c_rst_val_reg2[b];
                if (depth > c_addr_reg3 && (c_addr_reg3 * width + b) < c_rst_img_bits)
                    v[c_addr_reg3 * width + b] = c_rst_val_reg3[b];
            end
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_dp.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_dp
// Description : Dual-port configuration register file. It has one write port
//               and one read port, both usable in the same cycle, with
//               read-after-write bypass, per-register reset values, a
//               per-register write lock and address-range error reporting.
//               Registers 0..NUM_CFG-1 are exported on CFG_REGS.
// Ports       : CLK, RST           - clock, synchronous active-high reset
//               WrEn/WrAddr/WrData - write request
//               RdEn/RdAddr        - read request
//               RdData, RdData_VLD - registered read data and valid pulse
//               wr_done            - pulse one cycle after an accepted write
//               addr_err           - pulse one cycle after any rejected request
//               CFG_REGS           - registers 0..NUM_CFG-1, reg0 in the LSBs
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_dp
    import sys_cfg_pkg::*;
#(
    parameter int                     WIDTH     = 8,
    parameter int                     DEPTH     = 16,
    parameter int                     NUM_CFG   = 4,
    parameter logic [DEPTH*WIDTH-1:0] RST_VALS  = (DEPTH*WIDTH)'(default_rst_vals(WIDTH, DEPTH)),
    parameter logic [DEPTH-1:0]       LOCK_MASK = '0,
    localparam int                    ADDR_W    = addr_width(DEPTH)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       WrEn,
    input  logic [ADDR_W-1:0]          WrAddr,
    input  logic [WIDTH-1:0]           WrData,
    input  logic                       RdEn,
    input  logic [ADDR_W-1:0]          RdAddr,
    output logic [WIDTH-1:0]           RdData,
    output logic                       RdData_VLD,
    output logic                       wr_done,
    output logic                       addr_err,
    output logic [NUM_CFG*WIDTH-1:0]   CFG_REGS
);

    // Full address space of the address bus; DEPTH need not fill it
    localparam int               c_span  = 1 << ADDR_W;
    // DEPTH held one bit wider than the address so the range compare is exact
    localparam logic [ADDR_W:0]  c_depth = (ADDR_W + 1)'(DEPTH);
    // Lock mask widened to the whole address space; absent registers read 0
    localparam logic [c_span-1:0] c_lock_ext = c_span'(LOCK_MASK);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_vld;
    logic             r_wr_done;
    logic             r_addr_err;

    logic w_wr_in_range;
    logic w_rd_in_range;
    logic w_wr_locked;
    logic w_wr_accept;
    logic w_wr_reject;
    logic w_rd_reject;
    logic w_bypass;

    assign w_wr_in_range = ({1'b0, WrAddr} < c_depth);
    assign w_rd_in_range = ({1'b0, RdAddr} < c_depth);
    assign w_wr_locked   = c_lock_ext[WrAddr];
    assign w_wr_accept   = WrEn && w_wr_in_range && !w_wr_locked;
    assign w_wr_reject   = WrEn && !w_wr_accept;
    assign w_rd_reject   = RdEn && !w_rd_in_range;
    // A read of the register being written this cycle returns the new data
    assign w_bypass      = w_wr_accept && (WrAddr == RdAddr);

    // Storage
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (RST) begin
                r_mem[i] <= RST_VALS[i*WIDTH +: WIDTH];
            end else if (w_wr_accept && (WrAddr == ADDR_W'(i))) begin
                r_mem[i] <= WrData;
            end
        end
    end

    // Read port and status pulses
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_data  <= '0;
            r_rd_vld   <= 1'b0;
            r_wr_done  <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_rd_vld   <= RdEn;
            r_wr_done  <= w_wr_accept;
            r_addr_err <= w_wr_reject || w_rd_reject;
            if (RdEn) begin
                if (!w_rd_in_range) begin
                    r_rd_data <= '0;
                end else if (w_bypass) begin
                    r_rd_data <= WrData;
                end else begin
                    r_rd_data <= r_mem[RdAddr];
                end
            end
        end
    end

    assign RdData     = r_rd_data;
    assign RdData_VLD = r_rd_vld;
    assign wr_done    = r_wr_done;
    assign addr_err   = r_addr_err;

    // Configuration export comes straight from storage, so no bypass applies
    generate
        for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg
            assign CFG_REGS[k*WIDTH +: WIDTH] = r_mem[k];
        end
    endgenerate

endmodule
`default_nettype wire
